fetch_queue: RTL and testbench

Dual-wide instruction fetch unit with a decoupling instruction queue. It sits directly upstream of the decode stage. It reads two 32-bit instructions per request (8 bytes, big-endian) from instruction memory, buffers them in order, and presents the oldest pair to decode under a valid/ready handshake. A zero instruction word, or the end of memory, ends the program.

---
 rtl/fetch_queue.sv | 170 +++++++++++++++++
 tb/tb_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Dual-wide instruction fetch with an in-order decoupling queue feeding decode.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module fetch_queue #(
  parameter int IMEM_BYTES = 128,
  parameter int QDEPTH     = 8,
  parameter int AW         = $clog2(IMEM_BYTES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      imem_req,
  output logic [AW-1:0]             imem_addr,
  input  logic [63:0]               imem_rdata,
  output logic                      dec_valid_1,
  output logic [31:0]               dec_instr_1,
  output logic                      dec_valid_2,
  output logic [31:0]               dec_instr_2,
  input  logic                      dec_ready,
  output logic                      halted,
  output logic [$clog2(QDEPTH):0]   q_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_stall
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic            disc_q, disc_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     mem_q [QDEPTH];

  logic [CW-1:0]   free_slots;
  logic [CW-1:0]   need_slots;
  logic            credit_ok;
  logic            req;
  logic            last_req;
  logic [31:0]     w1, w2;
  logic            rsp_vld;
  logic            rsp_term;
  logic [1:0]      enq_n, deq_n;
  logic [PW-1:0]   head_nx;

  assign w1 = imem_rdata[63:32];
  assign w2 = imem_rdata[31:0];

  // Reserve room for the response already in flight plus the one requested now.
  assign free_slots = QDEPTH_C - count_q;
  assign need_slots = inflight_q ? CW'(4) : CW'(2);
  assign credit_ok  = free_slots >= need_slots;
  assign req        = (state_q == S_RUN) && credit_ok;
  assign last_req   = ({1'b0, pc_q} + (AW+1)'(8)) == (AW+1)'(IMEM_BYTES);

  // Responses to requests issued alongside or after a terminating one are dropped.
  assign rsp_vld  = inflight_q && !disc_q;
  assign rsp_term = rsp_vld && ((w1 == 32'd0) || (w2 == 32'd0));

  always_comb begin
    enq_n = 2'd0;
    if (rsp_vld && (w1 != 32'd0)) begin
      enq_n = (w2 != 32'd0) ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    deq_n = 2'd0;
    if (dec_ready) begin
      if (count_q >= CW'(2)) begin
        deq_n = 2'd2;
      end else if (count_q != '0) begin
        deq_n = 2'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = req ? pc_q + AW'(8) : pc_q;
    inflight_d = req;
    disc_d     = disc_q | rsp_term;
    count_d    = count_q + CW'(enq_n) - CW'(deq_n);
    head_d     = head_q + PW'(deq_n);
    tail_d     = tail_q + PW'(enq_n);
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (rsp_term || (req && last_req)) state_d = S_DRAIN;
      S_DRAIN: if ((count_q == '0) && (!inflight_q || disc_q)) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      disc_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      disc_q     <= disc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_n != 2'd0) begin
      mem_q[tail_q] <= w1;
    end
    if (enq_n == 2'd2) begin
      mem_q[tail_q + PW'(1)] <= w2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(count_q) + int'(enq_n) - int'(deq_n) <= QDEPTH)
        else $error("fetch_queue overflow");
    end
  end

  assign head_nx     = head_q + PW'(1);
  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign dec_valid_1 = count_q != '0;
  assign dec_valid_2 = count_q >= CW'(2);
  assign dec_instr_1 = mem_q[head_q];
  assign dec_instr_2 = mem_q[head_nx];
  assign halted      = state_q == S_HALT;
  assign q_count     = count_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;
  logic [32:0] fetched_sum;

  assign fetched_sum = {1'b0, perf_fetched_q} + 33'(enq_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      if ((state_q == S_RUN) && !credit_ok && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a 128-byte instance for most scenarios and a 16-byte one for end-of-memory.
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, dec_ready;
  logic        imem_req;
  logic [6:0]  imem_addr;
  logic [63:0] imem_rdata;
  logic        dec_valid_1, dec_valid_2, halted;
  logic [31:0] dec_instr_1, dec_instr_2;
  logic [3:0]  q_count;

  logic        start2, dec_ready2;
  logic        imem_req2;
  logic [3:0]  imem_addr2;
  logic [63:0] imem_rdata2;
  logic        dec_valid_1_2, dec_valid_2_2, halted2;
  logic [31:0] dec_instr_1_2, dec_instr_2_2;
  logic [3:0]  q_count2;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

  fetch_queue #(.IMEM_BYTES(128), .QDEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dec_valid_1(dec_valid_1), .dec_instr_1(dec_instr_1),
    .dec_valid_2(dec_valid_2), .dec_instr_2(dec_instr_2),
    .dec_ready(dec_ready), .halted(halted), .q_count(q_count)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  fetch_queue #(.IMEM_BYTES(16), .QDEPTH(8)) u_small (
    .clk(clk), .rst(rst), .start(start2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .dec_valid_1(dec_valid_1_2), .dec_instr_1(dec_instr_1_2),
    .dec_valid_2(dec_valid_2_2), .dec_instr_2(dec_instr_2_2),
    .dec_ready(dec_ready2), .halted(halted2), .q_count(q_count2)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched2), .perf_stall(perf_stall2)
`endif
  );

  // Instruction memories: one-cycle read latency.
  logic [31:0] mem  [0:31];
  logic [31:0] mem2 [0:3];
  logic [6:0]  raddr = '0;
  logic [3:0]  raddr2 = '0;
  always @(posedge clk) if (imem_req) raddr <= imem_addr;
  always @(posedge clk) if (imem_req2) raddr2 <= imem_addr2;
  assign imem_rdata  = {mem[raddr[6:2]], mem[raddr[6:2] + 5'd1]};
  assign imem_rdata2 = {mem2[raddr2[3:2]], mem2[raddr2[3:2] + 2'd1]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] got[$];
  logic [31:0] g2[$];
  int req_addr[$];
  int req_cyc[$];
  int last_pop_cyc, halt_cyc, stall_m, prev_addr, n2;
  bit halt_seen, run_m, prev_req, h2;
  logic last_v1, last_v2;
  logic [31:0] last_i1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic bit term_at(input int a);
    return (mem[a/4] == 32'd0) || (mem[a/4 + 1] == 32'd0);
  endfunction

  task automatic clear_rec();
    got.delete(); req_addr.delete(); req_cyc.delete();
    halt_seen = 0; halt_cyc = -1; last_pop_cyc = -1;
    last_v1 = 0; last_v2 = 0; last_i1 = '0;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < 32; i++) mem[i] = (i < n) ? base + 32'(i) : 32'd0;
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; start2 = 1'b0; dec_ready = 1'b0; dec_ready2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_m = 1; stall_m = 0; prev_req = 0; prev_addr = 0;
  endtask

  // One iteration per cycle, sampling at the falling edge; also models RUN stall cycles.
  task automatic run(input int n, input logic rdy, input bit stop_halt);
    for (int i = 0; i < n; i++) begin
      dec_ready = rdy;
      if (stop_halt && halted) begin
        halt_seen = 1; halt_cyc = cyc;
        break;
      end
      if (rdy && dec_valid_1) begin
        got.push_back(dec_instr_1);
        last_v1 = 1'b1; last_i1 = dec_instr_1; last_v2 = dec_valid_2; last_pop_cyc = cyc;
      end
      if (rdy && dec_valid_2) got.push_back(dec_instr_2);
      if (run_m && !imem_req) stall_m++;
      if (run_m && ((prev_req && term_at(prev_addr)) || (imem_req && int'(imem_addr) == 120)))
        run_m = 0;
      prev_req = imem_req; prev_addr = int'(imem_addr);
      if (imem_req) begin
        req_addr.push_back(int'(imem_addr)); req_cyc.push_back(cyc);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; dec_ready = 1'b0; dec_ready2 = 1'b0;
    fill(0, 32'd0);
    for (int i = 0; i < 4; i++) mem2[i] = 32'h0010_0093 + 32'(i << 8);

    // Scenario 1: four-instruction program
    reset_all();
    chk("rst_q_count", q_count, 0);
    chk("rst_valid_1", dec_valid_1, 0);
    chk("rst_valid_2", dec_valid_2, 0);
    chk("rst_halted", halted, 0);
    chk("rst_imem_req", imem_req, 0);
    fill(0, 32'd0);
    mem[0] = 32'h0050_0093; mem[1] = 32'h0060_0113;
    mem[2] = 32'h0020_81B3; mem[3] = 32'h4020_8233;
    clear_rec();
    start_pulse();
    run(60, 1'b1, 1'b1);
    chk("s1_addr0", (req_addr.size() > 0) ? req_addr[0] : -1, 0);
    chk("s1_addr1", (req_addr.size() > 1) ? req_addr[1] : -1, 8);
    chk("s1_consec", (req_cyc.size() > 1) ? req_cyc[1] - req_cyc[0] : -1, 1);
    chk("s1_n_out", got.size(), 4);
    chk("s1_i0", got_at(0), 32'h0050_0093);
    chk("s1_i1", got_at(1), 32'h0060_0113);
    chk("s1_i2", got_at(2), 32'h0020_81B3);
    chk("s1_i3", got_at(3), 32'h4020_8233);
    chk("s1_halted", halt_seen, 1);
    chk("s1_halt_lat", (halt_seen && (halt_cyc - last_pop_cyc) <= 3), 1);

    // Scenario 2: 12 instructions with decode stalled, then released
    reset_all();
    fill(12, 32'hA000_0001);
    clear_rec();
    start_pulse();
    run(10, 1'b0, 1'b0);
    req_addr.delete();
    run(20, 1'b0, 1'b0);
    chk("s2_q_full", q_count, 8);
    chk("s2_no_req", req_addr.size(), 0);
    chk("s2_req_now", imem_req, 0);
    got.delete();
    run(120, 1'b1, 1'b1);
    chk("s2_n_out", got.size(), 12);
    for (int i = 0; i < 12; i++) chk($sformatf("s2_i%0d", i), got_at(i), 32'hA000_0001 + 32'(i));
    chk("s2_halted", halt_seen, 1);
`ifdef FETCH_PERF_EN
    chk("s2_perf_fetched", perf_fetched, 12);
    chk("s2_perf_stall", perf_stall, stall_m);
`endif

    // Scenario 3: second word of a pair is zero
    reset_all();
    fill(0, 32'd0);
    mem[0] = 32'h0010_0093; mem[1] = 32'h0020_0113;
    mem[2] = 32'h00A0_0513; mem[3] = 32'd0;
    mem[4] = 32'hDEAD_BEEF; mem[5] = 32'hDEAD_BEEF;
    clear_rec();
    start_pulse();
    run(60, 1'b1, 1'b1);
    chk("s3_n_out", got.size(), 3);
    chk("s3_last", got_at(2), 32'h00A0_0513);
    chk("s3_last_v1", last_v1, 1);
    chk("s3_last_i1", last_i1, 32'h00A0_0513);
    chk("s3_last_v2", last_v2, 0);
    chk("s3_halted", halt_seen, 1);
    chk("s3_q_count", q_count, 0);

    // Scenario 4: 16-byte memory, all words nonzero
    reset_all();
    g2.delete(); n2 = 0; h2 = 0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      dec_ready2 = 1'b1;
      if (halted2) begin
        h2 = 1;
        break;
      end
      if (dec_valid_1_2) g2.push_back(dec_instr_1_2);
      if (dec_valid_2_2) g2.push_back(dec_instr_2_2);
      if (imem_req2) n2++;
      @(negedge clk);
    end
    chk("s4_n_out", g2.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("s4_i%0d", i), (i < g2.size()) ? g2[i] : 32'hFFFF_FFFF, mem2[i]);
    chk("s4_n_req", n2, 2);
    chk("s4_halted", h2, 1);

    // Scenario 5: reset right after a request
    reset_all();
    fill(12, 32'hB000_0001);
    clear_rec();
    start_pulse();
    chk("s5_req", imem_req, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s5_q_count_a", q_count, 0);
    @(negedge clk);
    chk("s5_q_count_b", q_count, 0);
    chk("s5_valid_1", dec_valid_1, 0);
    run_m = 0; prev_req = 0;
    clear_rec();
    run(6, 1'b0, 1'b0);
    chk("s5_idle_req", req_addr.size(), 0);
    chk("s5_halted", halted, 0);
    clear_rec();
    start_pulse();
    run(120, 1'b1, 1'b1);
    chk("s5_restart_n", got.size(), 12);
    chk("s5_restart_first", got_at(0), 32'hB000_0001);
    chk("s5_restart_halt", halt_seen, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
